regfile_bram_multi: RTL
=======================

Name: regfile_bram_multi

Overview:
- Parametrised BRAM-backed register file for the FPU and integer register banks.
- One write port and NUM_READ synchronous read ports. Each read port is a replicated simple-dual-port BRAM bank.
- Adds three things: registered same-cycle write forwarding, an optional hard-wired zero register, and a hardware clear sequencer that zeroes every entry after reset or on request.

Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 5, address width
- DEPTH, 32, number of entries; must satisfy DEPTH <= 2**ADDR_W
- NUM_READ, 3, number of read ports (1..4)
- ZERO_REG, 0, when 1, entry 0 always reads 0 and writes to it are dropped

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clr_req  in  1  one-cycle pulse; starts a full clear when ready=1
- ready  out  1  1 when the clear sequencer is idle and the file is usable
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- re  in  NUM_READ  per-port read enable; 0 holds that port's rd
- rclr  in  NUM_READ  per-port synchronous output clear
- ra  in  NUM_READ*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd  out  NUM_READ*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset and clock: one clock (clk); reset rst is synchronous and active-high.
- Reset values: rd=0 on all ports, ready=0, clear counter=0, FSM in CLEAR. BRAM contents are not reset directly; the sequencer zeroes them.
- FSM states:
  - CLEAR: each cycle, write 0 to address cnt in every bank, then cnt++. When cnt==DEPTH-1 has been written, go to RUN and ready becomes 1 on the following cycle. A full clear takes DEPTH cycles.
  - RUN: normal operation. clr_req=1 -> CLEAR with cnt=0 and ready=0 on the next cycle.
- rst asserted mid-CLEAR restarts at cnt=0. clr_req is ignored while in CLEAR.
- In CLEAR, external we is ignored, and rd of enabled ports loads 0.
- Write path (RUN): when we=1, wd is written to wa in all NUM_READ banks at the clock edge.
  - wa >= DEPTH: write dropped.
  - ZERO_REG=1 and wa==0: write dropped.
- Read latency is 1 cycle. re[i]=1 at edge t -> rd[i] holds the value for ra[i] after edge t. With re[i]=0, rd[i] holds its value.
- Forwarding: if re[i], we, and wa==ra[i] coincide at the same edge (and the write is not dropped), rd[i] after that edge equals wd, not the stale BRAM data. The bypass is selected by a registered flag plus registered data, so there is no combinational path from wd to rd.
- Zero register: ZERO_REG=1 and ra[i]==0 -> rd[i]=0, regardless of any write.
- Out of range: ra[i] >= DEPTH -> rd[i]=0.
- Output clear priority: rclr[i]=1 -> rd[i]=0 after the edge. This overrides re[i] and forwarding. rst overrides everything.
- Port independence: each port's re, rclr and forwarding act only on that port.
- Simultaneous clr_req and we in RUN: the write completes, then CLEAR overwrites it with 0.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum {CLEAR, RUN}.
  - Default width constants (DATA_W=32, ADDR_W=5, DEPTH=32).
- Sub-module regfile_bank_sdp, instantiated NUM_READ times by a generate loop:
  - One simple-dual-port BRAM bank: write port A, synchronous read port B with enable.
  - No reset on the memory array.
- Top level owns:
  - Clear FSM and counter.
  - Write muxing between the sequencer and we/wa/wd.
  - Per-port forwarding registers.
  - rclr and zero-register masking.

Test Plan:
- Reset then idle: ready=0 for exactly 32 cycles after rst deasserts, then 1. Reads of addr 0..31 on all ports return 0x00000000.
- Write then read, RUN: we=1, wa=5, wd=0x3F800000, then next cycle re=3'b111, ra={5,5,5} -> all rd=0x3F800000 one cycle later.
- Same-cycle forwarding: we=1, wa=7, wd=0x40490FDB with re[1]=1, ra[1]=7 (old value 0x11111111) -> rd[1]=0x40490FDB next cycle; rd[0] (ra[0]=8) unaffected.
- rclr and hold: rd[2]=0xDEADBEEF, then re[2]=0 for 3 cycles -> value held; then rclr[2]=1 with re[2]=1 -> rd[2]=0 next cycle.
- ZERO_REG=1 build: we=1, wa=0, wd=0xFFFFFFFF, then read addr 0 -> 0, including the same-cycle forwarding case.
- Clear behaviour:
  - clr_req in RUN after writing 0x12345678 to addr 31 -> ready drops, writes during CLEAR are ignored, and addr 31 reads 0 after ready returns.
  - rst pulsed at cnt=10 -> a full 32-cycle clear restarts.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default widths for the BRAM register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_bank_sdp.sv
// ============================================================================
// Module      : regfile_bank_sdp
// Description : Simple-dual-port BRAM bank, write port A, enabled sync read B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bank_sdp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // No reset on the array so the tools can map it onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule : regfile_bank_sdp

`default_nettype wire

// File: rtl/regfile_bram_multi.sv
// ============================================================================
// Module      : regfile_bram_multi
// Description : Multi-read-port BRAM register file with write forwarding,
//               optional zero register and a hardware clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bram_multi
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_READ = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    output logic                       ready,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic [NUM_READ-1:0]        re,
    input  logic [NUM_READ-1:0]        rclr,
    input  logic [NUM_READ*ADDR_W-1:0] ra,
    output logic [NUM_READ*DATA_W-1:0] rd
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    logic              w_wr_ok;
    logic              w_bank_we;
    logic [ADDR_W-1:0] w_bank_wa;
    logic [DATA_W-1:0] w_bank_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == C_LAST) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;

    // A write is accepted only in RUN, in range, and not to a hard-wired zero.
    assign w_wr_ok = (state_q == RUN) && we && (32'(wa) < DEPTH) &&
                     !((ZERO_REG != 0) && (wa == '0));

    assign w_bank_we = (state_q == CLEAR) ? 1'b1  : w_wr_ok;
    assign w_bank_wa = (state_q == CLEAR) ? cnt_q : wa;
    assign w_bank_wd = (state_q == CLEAR) ? '0    : wd;

    generate
        for (genvar i = 0; i < NUM_READ; i++) begin : g_port
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_bank_rd;
            logic              w_ra_zero;
            logic              w_hit;
            logic              zero_q;
            logic              fwd_q;
            logic [DATA_W-1:0] fwd_data_q;

            assign w_ra      = ra[i*ADDR_W +: ADDR_W];
            assign w_ra_zero = (32'(w_ra) >= DEPTH) ||
                               ((ZERO_REG != 0) && (w_ra == '0));
            assign w_hit     = w_wr_ok && (wa == w_ra);

            regfile_bank_sdp #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH)
            ) u_bank (
                .clk     (clk),
                .we_i    (w_bank_we),
                .waddr_i (w_bank_wa),
                .wdata_i (w_bank_wd),
                .re_i    (re[i]),
                .raddr_i (w_ra),
                .rdata_o (w_bank_rd)
            );

            // Flags pick between zero, captured write data and BRAM output.
            always_ff @(posedge clk) begin
                if (rst || rclr[i]) begin
                    zero_q <= 1'b1;
                    fwd_q  <= 1'b0;
                end else if (re[i]) begin
                    if ((state_q == CLEAR) || w_ra_zero) begin
                        zero_q <= 1'b1;
                        fwd_q  <= 1'b0;
                    end else begin
                        zero_q <= 1'b0;
                        fwd_q  <= w_hit;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (re[i] && w_hit) begin
                    fwd_data_q <= wd;
                end
            end

            assign rd[i*DATA_W +: DATA_W] = zero_q ? '0 :
                                            (fwd_q ? fwd_data_q : w_bank_rd);
        end
    endgenerate

endmodule : regfile_bram_multi

`default_nettype wire
